pc_sequencer: RTL

Next-address controller for the single-cycle core's 4-bit program counter. Each cycle it selects the address the PC register loads: sequential, jump, conditional PC-relative branch, call, return, stall hold or halt hold. It owns a small hardware return-address stack and a BOOT/RUN/HALT state machine. `next` drives the PC register's `next` input, and the PC register's `pc` output feeds back into this block.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/address bundle between the core and the
// next-address controller. The master side is the core (it presents the
// current PC and the control requests); the slave side is pc_sequencer.
interface pc_sequencer_if;
  logic [3:0] pc;
  logic       halt;
  logic       resume;
  logic       stall;
  logic       jump;
  logic       call;
  logic       ret;
  logic       branch;
  logic       cond;
  logic [3:0] target;
  logic [3:0] offset;
  logic [3:0] next;
  logic       taken;
  logic [1:0] state;
  logic [2:0] sp;
  logic       stack_err;

  modport master (
    output pc, halt, resume, stall, jump, call, ret, branch, cond, target, offset,
    input  next, taken, state, sp, stack_err
  );

  modport slave (
    input  pc, halt, resume, stall, jump, call, ret, branch, cond, target, offset,
    output next, taken, state, sp, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address controller for the 4-bit program counter.
// Picks the address the PC register loads each cycle (sequential, jump,
// taken branch, call, return, stall/halt hold) and runs the BOOT/RUN/HALT
// state machine. next/taken are combinational so the PC register captures
// them at the same edge.
//
// Optional feature macro: PC_SEQ_RET_STACK_EN
//   defined   -> hardware return-address stack; call pushes, ret pops.
//   undefined -> no stack; call acts as jump, ret falls through to the next
//                lower priority request, sp and stack_err read as 0.
module pc_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t     stateQ;
  logic [3:0] pcInc;
  logic [3:0] branchAddr;
  logic [3:0] nextAddr;
  logic       takenOut;
  logic       goHalt;

  assign pcInc = bus.pc + 4'd1;
  // A 4-bit add wraps mod 16, which is exactly pc + sext(offset) mod 16.
  assign branchAddr = bus.pc + bus.offset;

`ifdef PC_SEQ_RET_STACK_EN
  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [3:0]      stackMem [STACK_DEPTH];
  logic [2:0]      spQ;
  logic            errQ;
  logic            doPush;
  logic            doPop;
  logic            errSet;
  logic            stackFull;
  logic            stackEmpty;
  logic [IDXW-1:0] pushIdx;
  logic [IDXW-1:0] topIdx;
  logic [3:0]      stackTop;
  logic [2:0]      spDec;

  assign stackFull  = (spQ == 3'(STACK_DEPTH));
  assign stackEmpty = (spQ == 3'd0);
  assign spDec      = spQ - 3'd1;
  assign pushIdx    = spQ[IDXW-1:0];
  assign topIdx     = spDec[IDXW-1:0];
  assign stackTop   = stackMem[topIdx];

  // Next-address selection in priority order, with stack push/pop decisions.
  always_comb begin
    nextAddr = pcInc;
    takenOut = 1'b0;
    goHalt   = 1'b0;
    doPush   = 1'b0;
    doPop    = 1'b0;
    errSet   = 1'b0;
    case (stateQ)
      BOOT: nextAddr = 4'd0;
      HALT: nextAddr = bus.pc;
      RUN: begin
        if (bus.halt) begin
          nextAddr = bus.pc;
          goHalt   = 1'b1;
        end else if (bus.stall) begin
          nextAddr = bus.pc;
        end else if (bus.ret) begin
          if (stackEmpty) begin
            nextAddr = pcInc;
            errSet   = 1'b1;
          end else begin
            nextAddr = stackTop;
            takenOut = 1'b1;
            doPop    = 1'b1;
          end
        end else if (bus.call) begin
          nextAddr = bus.target;
          takenOut = 1'b1;
          if (stackFull) begin
            errSet = 1'b1;
          end else begin
            doPush = 1'b1;
          end
        end else if (bus.jump) begin
          nextAddr = bus.target;
          takenOut = 1'b1;
        end else if (bus.branch && bus.cond) begin
          nextAddr = branchAddr;
          takenOut = 1'b1;
        end
      end
      default: nextAddr = 4'd0;
    endcase
  end

  // Return-address storage; contents are don't-care after reset so no reset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      stackMem[pushIdx] <= pcInc;
    end
  end

  // Control state machine plus stack pointer and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= BOOT;
      spQ    <= 3'd0;
      errQ   <= 1'b0;
    end else begin
      case (stateQ)
        BOOT: stateQ <= RUN;
        RUN:  if (goHalt) stateQ <= HALT;
        HALT: if (bus.resume) stateQ <= RUN;
        default: stateQ <= BOOT;
      endcase
      if (doPush) begin
        spQ <= spQ + 3'd1;
      end else if (doPop) begin
        spQ <= spDec;
      end
      if (errSet) begin
        errQ <= 1'b1;
      end
    end
  end

  assign bus.sp        = spQ;
  assign bus.stack_err = errQ;

`else

  // Next-address selection in priority order; call is a plain jump and ret
  // is not decoded, so it falls through to whatever is requested below it.
  always_comb begin
    nextAddr = pcInc;
    takenOut = 1'b0;
    goHalt   = 1'b0;
    case (stateQ)
      BOOT: nextAddr = 4'd0;
      HALT: nextAddr = bus.pc;
      RUN: begin
        if (bus.halt) begin
          nextAddr = bus.pc;
          goHalt   = 1'b1;
        end else if (bus.stall) begin
          nextAddr = bus.pc;
        end else if (bus.call || bus.jump) begin
          nextAddr = bus.target;
          takenOut = 1'b1;
        end else if (bus.branch && bus.cond) begin
          nextAddr = branchAddr;
          takenOut = 1'b1;
        end
      end
      default: nextAddr = 4'd0;
    endcase
  end

  // Control state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= BOOT;
    end else begin
      case (stateQ)
        BOOT: stateQ <= RUN;
        RUN:  if (goHalt) stateQ <= HALT;
        HALT: if (bus.resume) stateQ <= RUN;
        default: stateQ <= BOOT;
      endcase
    end
  end

  assign bus.sp        = 3'd0;
  assign bus.stack_err = 1'b0;

`endif

  assign bus.next  = nextAddr;
  assign bus.taken = takenOut;
  assign bus.state = stateQ;

endmodule
